// File: rtl/crc_rx_frame_ctrl.sv
// Receive-side sequencer for a bit-serial CRC-16 checker: paces byte loads,
// bounds frame length, waits for the end-of-check strobe and reports a verdict.
module crc_rx_frame_ctrl #(
  parameter int unsigned LEN_W    = 5,
  parameter int unsigned MAX_LEN  = 31,
  parameter int unsigned MIN_LEN  = 3,
  parameter int unsigned LOAD_GAP = 18,
  parameter int unsigned WDOG     = 24,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              crc_load_o,
  output logic [7:0]        crc_byte_o,
  output logic              crc_init_o,
  output logic [LEN_W-1:0]  crc_max_offset_o,
  input  logic              crc_eoch_i,
  input  logic              crc_ok_i,
  output logic              frame_done_o,
  output logic              frame_ok_o,
  output logic              err_len_o,
  output logic              err_tmo_o,
  output logic [STAT_W-1:0] ok_cnt_o,
  output logic [STAT_W-1:0] err_cnt_o,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a byte transfers on a rising edge where in_valid_i & in_ready_o;
  // in_ready_o depends only on registered state, never on in_valid_i.

  localparam int unsigned GAP_W = $clog2(LOAD_GAP + 1);
  localparam int unsigned WD_W  = $clog2(WDOG + 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_ACCEPT = 3'd1,
    S_DRAIN  = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [GAP_W-1:0]    init_cnt_q, init_cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                load_q, load_d;
  logic [7:0]          byte_q, byte_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                err_len_q, err_len_d;
  logic                err_tmo_q, err_tmo_d;
  logic                ok_lat_q, ok_lat_d;
  logic [STAT_W-1:0]   ok_cnt_q, ok_cnt_d;
  logic [STAT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [LEN_W-1:0]    cnt_inc;
  logic                verdict_ok;

  assign cnt_inc    = cnt_q + 1'b1;
  assign verdict_ok = ok_lat_q & ~err_len_q & ~err_tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= GAP_W'(LOAD_GAP);
      gap_q      <= '0;
      cnt_q      <= '0;
      load_q     <= 1'b0;
      byte_q     <= 8'h00;
      wdog_q     <= '0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      ok_lat_q   <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      byte_q     <= byte_d;
      wdog_q     <= wdog_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
      ok_lat_q   <= ok_lat_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    load_d     = 1'b0;
    byte_d     = byte_q;
    wdog_d     = wdog_q;
    err_len_d  = err_len_q;
    err_tmo_d  = err_tmo_q;
    ok_lat_d   = ok_lat_q;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
    in_ready_o = 1'b0;
    unique case (state_q)
      S_INIT: begin
        cnt_d = '0;
        gap_d = '0;
        if (init_cnt_q <= GAP_W'(1)) state_d = S_ACCEPT;
        else init_cnt_d = init_cnt_q - 1'b1;
      end
      S_ACCEPT: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            // A non-final byte that would reach MAX_LEN can never be legal.
            if (!in_last_i && (cnt_inc == LEN_W'(MAX_LEN))) begin
              err_len_d = 1'b1;
              state_d   = S_DRAIN;
            end else begin
              load_d = 1'b1;
              byte_d = in_data_i;
              cnt_d  = cnt_inc;
              gap_d  = GAP_W'(LOAD_GAP - 1);
              if (in_last_i) begin
                wdog_d  = '0;
                state_d = S_WAIT;
                if (cnt_inc < LEN_W'(MIN_LEN)) err_len_d = 1'b1;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        in_ready_o = 1'b1;
        if (in_valid_i && in_last_i) begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // An end-of-check coinciding with a load belongs to an earlier byte.
        if (crc_eoch_i && !load_q) begin
          ok_lat_d = crc_ok_i;
          state_d  = S_REPORT;
        end else if (wdog_q == WD_W'(WDOG - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = S_REPORT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_REPORT: begin
        if (verdict_ok) begin
          if (ok_cnt_q != {STAT_W{1'b1}}) ok_cnt_d = ok_cnt_q + 1'b1;
        end else begin
          if (err_cnt_q != {STAT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        end
        err_len_d  = 1'b0;
        err_tmo_d  = 1'b0;
        ok_lat_d   = 1'b0;
        init_cnt_d = GAP_W'(1);
        state_d    = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign crc_load_o       = load_q;
  assign crc_byte_o       = byte_q;
  assign crc_init_o       = (state_q == S_INIT);
  assign crc_max_offset_o = cnt_q;
  assign frame_done_o     = (state_q == S_REPORT);
  assign frame_ok_o       = frame_done_o & verdict_ok;
  assign err_len_o        = frame_done_o & err_len_q;
  assign err_tmo_o        = frame_done_o & err_tmo_q;
  assign ok_cnt_o         = ok_cnt_q;
  assign err_cnt_o        = err_cnt_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_crc_rx_frame_ctrl.sv
// Bench for crc_rx_frame_ctrl: behavioural serial CRC-16 checker, frame driver,
// and a verdict scoreboard keyed by frame order.
module tb_crc_rx_frame_ctrl;

  localparam int LEN_W  = 5;
  localparam int STAT_W = 16;
  localparam int W      = 17;  // {latency[7:0], loads[5:0], ok, err_len, err_tmo}

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              crc_load;
  logic [7:0]        crc_byte;
  logic              crc_init;
  logic [LEN_W-1:0]  crc_max_offset;
  logic              crc_eoch = 1'b0;
  logic              crc_ok = 1'b0;
  logic              frame_done, frame_ok, err_len, err_tmo;
  logic [STAT_W-1:0] ok_cnt, err_cnt;
  logic [2:0]        dbg_state;

  crc_rx_frame_ctrl #(
    .LEN_W(LEN_W), .MAX_LEN(31), .MIN_LEN(3), .LOAD_GAP(18), .WDOG(24), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last), .in_ready_o(in_ready),
    .crc_load_o(crc_load), .crc_byte_o(crc_byte), .crc_init_o(crc_init),
    .crc_max_offset_o(crc_max_offset), .crc_eoch_i(crc_eoch), .crc_ok_i(crc_ok),
    .frame_done_o(frame_done), .frame_ok_o(frame_ok), .err_len_o(err_len), .err_tmo_o(err_tmo),
    .ok_cnt_o(ok_cnt), .err_cnt_o(err_cnt), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] exp_q[$];
  logic [7:0]   fbuf[0:63];
  int           acc_cyc[0:63];

  // ---------------- checker model ----------------
  logic [15:0] m_crc = 16'hFFFF;
  int          m_pend = 0;
  bit          no_eoch = 1'b0;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  always @(negedge clk) begin
    crc_eoch = 1'b0;
    crc_ok   = 1'b0;
    if (crc_init) begin
      m_crc  = 16'hFFFF;
      m_pend = 0;
    end else begin
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0 && !no_eoch) begin
          crc_eoch = 1'b1;
          crc_ok   = (m_crc == 16'h0000);
        end
      end
      if (crc_load) begin
        m_crc  = crc_step(m_crc, crc_byte);
        m_pend = 17;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int nloads = 0;
  int last_load = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      nloads = 0;
    end else begin
      if (crc_load) begin
        nloads++;
        checks++;
        if (crc_max_offset !== LEN_W'(nloads)) begin
          errors++;
          $display("FAIL max_offset got %0d want %0d", crc_max_offset, nloads);
        end
        if (nloads > 1) begin
          checks++;
          if (cyc - last_load != 18) begin
            errors++;
            $display("FAIL load_spacing got %0d want 18", cyc - last_load);
          end
        end
        last_load = cyc;
      end
      if (frame_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_done got done=1 want none");
        end else begin
          e = exp_q.pop_front();
          if ({frame_ok, err_len, err_tmo} !== e[2:0]) begin
            errors++;
            $display("FAIL verdict got ok/len/tmo=%b want %b", {frame_ok, err_len, err_tmo}, e[2:0]);
          end
          checks++;
          if (nloads != int'(e[8:3])) begin
            errors++;
            $display("FAIL load_count got %0d want %0d", nloads, e[8:3]);
          end
          if (e[16:9] != 8'd0) begin
            checks++;
            if (cyc - last_load != int'(e[16:9])) begin
              errors++;
              $display("FAIL done_latency got %0d want %0d", cyc - last_load, e[16:9]);
            end
          end
        end
        nloads = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_good();
    fbuf[0] = 8'h01; fbuf[1] = 8'h03; fbuf[2] = 8'h00; fbuf[3] = 8'h00;
    fbuf[4] = 8'h00; fbuf[5] = 8'h01; fbuf[6] = 8'h84; fbuf[7] = 8'h0A;
  endtask

  task automatic send_frame(input int n, input bit term);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      in_valid = 1'b1;
      in_data  = fbuf[i];
      in_last  = term && (i == n - 1);
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (!in_ready) begin
        errors++;
        $display("FAIL in_ready_wait byte %0d got 0 want 1", i);
      end
      acc_cyc[i] = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    while (!frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL frame_done_wait got 0 want 1");
    end
    dc = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, crc_load, crc_init, frame_done, frame_ok, err_len, err_tmo} !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0010000",
               {in_ready, crc_load, crc_init, frame_done, frame_ok, err_len, err_tmo});
    end
    checks++;
    if (crc_byte !== 8'h00 || crc_max_offset !== '0) begin
      errors++;
      $display("FAIL reset_data got byte=%h off=%0d want 00/0", crc_byte, crc_max_offset);
    end
    checks++;
    if (ok_cnt !== '0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt got ok=%0d err=%0d want 0/0", ok_cnt, err_cnt);
    end
    rst = 1'b0;
    n = 0;
    while (crc_init && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 18) begin
      errors++;
      $display("FAIL init_len got %0d want 18", n);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init got %b want 1", in_ready);
    end
  endtask

  task automatic test_good_frame();
    int dc;
    load_good();
    exp_q.push_back({8'd18, 6'd8, 3'b100});
    send_frame(8, 1'b1);
    wait_done(dc);
    @(negedge clk);
    checks++;
    if (ok_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL good_cnt got ok=%0d err=%0d want 1/0", ok_cnt, err_cnt);
    end
  endtask

  task automatic test_bad_crc();
    int dc;
    load_good();
    fbuf[7] = 8'h0B;
    exp_q.push_back({8'd18, 6'd8, 3'b000});
    send_frame(8, 1'b1);
    wait_done(dc);
    @(negedge clk);
    checks++;
    if (ok_cnt !== 16'd1 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL bad_crc_cnt got ok=%0d err=%0d want 1/1", ok_cnt, err_cnt);
    end
  endtask

  task automatic test_short_frame();
    int dc;
    fbuf[0] = 8'h11;
    fbuf[1] = 8'h22;
    exp_q.push_back({8'd18, 6'd2, 3'b010});
    send_frame(2, 1'b1);
    wait_done(dc);
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL short_cnt got %0d want 2", err_cnt);
    end
  endtask

  task automatic test_long_frame();
    int dc;
    for (int i = 0; i < 40; i++) fbuf[i] = 8'($urandom_range(0, 255));
    exp_q.push_back({8'd0, 6'd30, 3'b011});
    send_frame(40, 1'b1);
    checks++;
    if (acc_cyc[39] - acc_cyc[30] != 9) begin
      errors++;
      $display("FAIL drain_rate got %0d want 9", acc_cyc[39] - acc_cyc[30]);
    end
    wait_done(dc);
    checks++;
    if (dc - acc_cyc[39] != 25) begin
      errors++;
      $display("FAIL drain_wdog got %0d want 25", dc - acc_cyc[39]);
    end
    @(negedge clk);
    checks++;
    if (err_cnt !== 16'd3) begin
      errors++;
      $display("FAIL long_cnt got %0d want 3", err_cnt);
    end
  endtask

  task automatic test_timeout();
    int dc;
    no_eoch = 1'b1;
    load_good();
    exp_q.push_back({8'd24, 6'd8, 3'b001});
    send_frame(8, 1'b1);
    wait_done(dc);
    no_eoch = 1'b0;
    @(negedge clk);
    checks++;
    if (crc_init !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_report_init got init=%b rdy=%b want 1/0", crc_init, in_ready);
    end
    @(negedge clk);
    checks++;
    if (crc_init !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL one_cycle_init got init=%b rdy=%b want 0/1", crc_init, in_ready);
    end
    exp_q.push_back({8'd18, 6'd8, 3'b100});
    send_frame(8, 1'b1);
    wait_done(dc);
    @(negedge clk);
    checks++;
    if (ok_cnt !== 16'd2 || err_cnt !== 16'd4) begin
      errors++;
      $display("FAIL timeout_cnt got ok=%0d err=%0d want 2/4", ok_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dc;
    load_good();
    send_frame(4, 1'b0);
    test_reset();
    exp_q.push_back({8'd18, 6'd8, 3'b100});
    send_frame(8, 1'b1);
    wait_done(dc);
    @(negedge clk);
    checks++;
    if (ok_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_cnt got ok=%0d err=%0d want 1/0", ok_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_short_frame();
    test_long_frame();
    test_timeout();
    test_reset_mid_frame();
    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_rx_frame_ctrl.md
Name: crc_rx_frame_ctrl

Overview:
- Receive-side sequencer that feeds a byte stream into the shared serial CRC-16 checker (poly 0xA001, init 0xFFFF, 16 shift cycles per byte).
- Paces byte loads to the checker's bit-serial throughput, drives its init and frame-length inputs, and qualifies its end-of-check strobe.
- Reports one pass/fail verdict per frame, with error causes, plus saturating statistics.
- Sits between the byte deframer and the packet buffer.

Parameters:
LEN_W, 5, width of byte counter and checker max-offset input (matches the checker's offset width)
MAX_LEN, 31, largest legal frame length in bytes, including the 2 CRC bytes (must be ≤ 2^LEN_W−1)
MIN_LEN, 3, smallest legal frame length in bytes
LOAD_GAP, 18, minimum number of cycles between successive crc_load pulses
WDOG, 24, number of cycles after the final crc_load within which crc_eoch must arrive
STAT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream byte valid
in_data  in  8  upstream byte
in_last  in  1  marks the final byte of a frame (the second CRC byte)
in_ready  out  1  byte is accepted on in_valid & in_ready
crc_load  out  1  one-cycle load strobe to the checker
crc_byte  out  8  byte presented to the checker; valid when crc_load=1
crc_init  out  1  checker init request
crc_max_offset  out  LEN_W  frame length driven to the checker
crc_eoch  in  1  checker end-of-check strobe
crc_ok  in  1  checker CRC-good strobe (qualified by crc_eoch)
frame_done  out  1  one-cycle verdict strobe
frame_ok  out  1  verdict; valid when frame_done=1
err_len  out  1  frame too short or too long; valid with frame_done
err_tmo  out  1  checker watchdog expired; valid with frame_done
ok_cnt  out  STAT_W  count of good frames, saturating
err_cnt  out  STAT_W  count of bad frames, saturating

Behaviour:
- Reset values:
  - state INIT, init counter = LOAD_GAP.
  - in_ready=0, crc_load=0, crc_byte=0, crc_init=1, crc_max_offset=0.
  - frame_done=frame_ok=err_len=err_tmo=0, ok_cnt=err_cnt=0.
- INIT:
  - crc_init=1 and byte count cleared.
  - Following reset, INIT lasts LOAD_GAP cycles so a checker still mid-shift finishes before init takes effect.
  - When entered from REPORT, INIT lasts 1 cycle.
  - Exits to ACCEPT.
- ACCEPT:
  - in_ready=1 only while the gap counter is 0.
  - On accept in cycle t: crc_load=1 and crc_byte=in_data in cycle t+1 (registered); count increments; gap counter loads LOAD_GAP−1 and counts down to 0.
  - in_ready is therefore 0 for cycles t+1..t+17; the next load is no earlier than cycle t+19.
- crc_max_offset is the registered byte count, updated in the same cycle as crc_load, so it tracks the checker's internal byte counter.
- crc_eoch is ignored in every state except WAIT_RES. The checker fires it after every byte because max_offset tracks its count.
- Accept with in_last=1:
  - count < MIN_LEN → err_len flagged; the byte is still loaded, and the state goes to WAIT_RES.
  - otherwise → WAIT_RES.
- Accept with in_last=0 while count+1 == MAX_LEN: err_len flagged, go to DRAIN.
- DRAIN:
  - in_ready=1 with no pacing; bytes are discarded with no crc_load.
  - On accept with in_last=1, go to WAIT_RES. The watchdog still applies and verdict = bad.
- WAIT_RES:
  - Watchdog counter starts at the final crc_load (or at DRAIN exit).
  - crc_eoch=1 → latch crc_ok, go to REPORT. Nominal arrival is 18 cycles after the final load.
  - Watchdog reaches WDOG with no crc_eoch → err_tmo=1, go to REPORT.
- REPORT (1 cycle):
  - frame_done=1.
  - frame_ok = crc_ok_latched & ~err_len & ~err_tmo.
  - Increment ok_cnt or err_cnt; each counter holds at all-ones.
  - Go to INIT.
- Error flags clear on entry to INIT.
- in_ready=0 in INIT, WAIT_RES and REPORT.
- crc_eoch and crc_load in the same cycle cannot occur by construction; if it happens anyway, crc_eoch is ignored.
- rst asserted in any state, including mid-frame or in DRAIN: all outputs return to reset values on the next edge. Any partial frame is dropped with no frame_done and no counter change.

Test Plan:
- Frame 01 03 00 00 00 01 84 0A (valid Modbus CRC), in_valid held high → 8 crc_load pulses exactly 18 cycles apart; frame_done 18 cycles after the 8th load with frame_ok=1; ok_cnt=1.
- Same frame with last byte 0x0B → frame_done with frame_ok=0, err_len=0, err_tmo=0; err_cnt=1.
- 2-byte frame (in_last on 2nd byte) → frame_done with frame_ok=0, err_len=1.
- 40-byte frame with MAX_LEN=31 → 30 loads, remaining 10 bytes drained with in_ready=1 each cycle, then frame_done with err_len=1.
- Checker model that never raises crc_eoch → frame_done exactly WDOG cycles after the last load with err_tmo=1; next frame passes normally after a 1-cycle crc_init.
- rst pulsed mid-frame (after 4 bytes) → no frame_done; crc_init high for 18 cycles; a following valid frame gives frame_ok=1 with ok_cnt=1, err_cnt=0.
